// File: rtl/truth_table_sweeper.sv
// Walks a 4-input combinational block through all 16 input vectors, records
// the sampled truth table and compares it against a captured expected table.
module truth_table_sweeper #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] expected,
  input  logic        f_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        not_a,
  output logic        not_b,
  output logic        not_c,
  output logic        not_d,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic [4:0]  mismatch_count,
  output logic [3:0]  first_fail,
  output logic        fail_valid,
  output logic        match
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SC_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  idx, scnt;
  logic [15:0] exp_q;

  // idx is the registered vector; it is parked at 0 outside a sweep
  assign {a, b, c, d} = idx;
  assign {not_a, not_b, not_c, not_d} = ~idx;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETTLE;
      SETTLE:  if (scnt == SC_LAST) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (idx == 4'd15) ? DONE : SETTLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      scnt           <= '0;
      exp_q          <= '0;
      table_out      <= '0;
      mismatch_count <= '0;
      first_fail     <= '0;
      fail_valid     <= 1'b0;
      match          <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          exp_q          <= expected;
          table_out      <= '0;
          mismatch_count <= '0;
          first_fail     <= '0;
          fail_valid     <= 1'b0;
          match          <= 1'b0;
          idx            <= '0;
          scnt           <= '0;
        end
        SETTLE: scnt <= scnt + 4'd1;
        SAMPLE: begin
          table_out[idx] <= f_in;
          if (f_in != exp_q[idx]) begin
            mismatch_count <= mismatch_count + 5'd1;
            if (!fail_valid) begin
              first_fail <= idx;
              fail_valid <= 1'b1;
            end
          end
          scnt <= '0;
          // last vector returns the outputs to 0000 for the DONE cycle
          idx  <= (idx == 4'd15) ? 4'd0 : idx + 4'd1;
        end
        DONE: match <= (mismatch_count == 5'd0);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: two sweepers (settle 2 with a real function, settle 1 with f tied high).
module tb_truth_table_sweeper;

  logic clk = 0;
  logic rst;
  logic start, start2;
  logic [15:0] expected, expected2;

  logic a1, b1, c1, d1, na1, nb1, nc1, nd1, busy1, done1, fv1, m1, f1;
  logic [15:0] tbl1;
  logic [4:0]  cnt1;
  logic [3:0]  ff1;

  logic a2, b2, c2, d2, na2, nb2, nc2, nd2, busy2, done2, fv2, m2;
  logic [15:0] tbl2;
  logic [4:0]  cnt2;
  logic [3:0]  ff2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] tbl;
    logic [4:0]  cnt;
    logic [3:0]  ff;
    logic        fv;
    logic        m;
  } res_t;

  res_t rq[$];
  int   vq[$];

  always #5 clk = ~clk;

  assign f1 = (a1 & b1) | (c1 & ~d1);

  truth_table_sweeper #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .expected(expected), .f_in(f1),
    .a(a1), .b(b1), .c(c1), .d(d1),
    .not_a(na1), .not_b(nb1), .not_c(nc1), .not_d(nd1),
    .busy(busy1), .done(done1), .table_out(tbl1), .mismatch_count(cnt1),
    .first_fail(ff1), .fail_valid(fv1), .match(m1)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .expected(expected2), .f_in(1'b1),
    .a(a2), .b(b2), .c(c2), .d(d2),
    .not_a(na2), .not_b(nb2), .not_c(nc2), .not_d(nd2),
    .busy(busy2), .done(done2), .table_out(tbl2), .mismatch_count(cnt2),
    .first_fail(ff2), .fail_valid(fv2), .match(m2)
  );

  function automatic logic f_ref(input int k);
    logic [3:0] v;
    v = 4'(k);
    return (v[3] & v[2]) | (v[1] & ~v[0]);
  endfunction

  task automatic check_results(input string nm, input logic [15:0] tbl, input logic [4:0] cnt,
                               input logic [3:0] ff, input logic fv, input logic m);
    res_t r;
    checks++;
    if (rq.size() == 0) begin
      errors++;
      $display("FAIL %s: result queue empty", nm);
    end else begin
      r = rq.pop_front();
      if (tbl !== r.tbl || cnt !== r.cnt || ff !== r.ff || fv !== r.fv || m !== r.m) begin
        errors++;
        $display("FAIL %s: got tbl=%h cnt=%0d ff=%0d fv=%b m=%b want tbl=%h cnt=%0d ff=%0d fv=%b m=%b",
                 nm, tbl, cnt, ff, fv, m, r.tbl, r.cnt, r.ff, r.fv, r.m);
      end
    end
  endtask

  // Full sweep on dut; expected outcome derived from f_ref and the given table.
  task automatic run_sweep(input logic [15:0] exp_t, input string nm);
    res_t r;
    logic fk;
    r.tbl = '0; r.cnt = '0; r.ff = '0; r.fv = 1'b0;
    for (int k = 0; k < 16; k++) begin
      fk = f_ref(k);
      r.tbl[k] = fk;
      if (fk != exp_t[k]) begin
        r.cnt++;
        if (!r.fv) begin r.ff = 4'(k); r.fv = 1'b1; end
      end
      vq.push_back(k);
    end
    r.m = (r.cnt == 0);
    rq.push_back(r);

    @(negedge clk);
    expected = exp_t;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    for (int cyc = 0; cyc < 48; cyc++) begin
      @(negedge clk);
      if (cyc == 10) expected = ~exp_t;  // captured copy must be used
      checks++;
      if (busy1 !== 1'b1 || done1 !== 1'b0) begin
        errors++;
        $display("FAIL %s busy/done cyc %0d: busy=%b done=%b want 1/0", nm, cyc, busy1, done1);
      end
      checks++;
      if ({na1, nb1, nc1, nd1} !== ~{a1, b1, c1, d1}) begin
        errors++;
        $display("FAIL %s complement cyc %0d: vec=%b not=%b", nm, cyc, {a1, b1, c1, d1}, {na1, nb1, nc1, nd1});
      end
      if (cyc % 3 == 2) begin
        checks++;
        if (vq.size() == 0) begin
          errors++;
          $display("FAIL %s vector queue empty cyc %0d", nm, cyc);
        end else begin
          int ev;
          ev = vq.pop_front();
          if ({a1, b1, c1, d1} !== 4'(ev)) begin
            errors++;
            $display("FAIL %s vector order: got %0d want %0d", nm, {a1, b1, c1, d1}, ev);
          end
        end
      end
    end
    @(negedge clk);
    checks++;
    if (done1 !== 1'b1 || busy1 !== 1'b1 || {a1, b1, c1, d1} !== 4'd0) begin
      errors++;
      $display("FAIL %s done cycle: done=%b busy=%b vec=%b want 1 1 0000", nm, done1, busy1, {a1, b1, c1, d1});
    end
    @(negedge clk);
    checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL %s after done: done=%b busy=%b want 0 0", nm, done1, busy1);
    end
    check_results({nm, " results"}, tbl1, cnt1, ff1, fv1, m1);
  endtask

  task automatic test_reset();
    rst = 1; start = 0; start2 = 0; expected = '0; expected2 = '0;
    #1;
    checks++;
    if ({a1, b1, c1, d1} !== 4'd0 || {na1, nb1, nc1, nd1} !== 4'hF || busy1 !== 0 || done1 !== 0 ||
        tbl1 !== 16'h0 || cnt1 !== 5'd0 || ff1 !== 4'd0 || fv1 !== 0 || m1 !== 0) begin
      errors++;
      $display("FAIL reset_values: vec=%b not=%b busy=%b done=%b tbl=%h cnt=%0d ff=%0d fv=%b m=%b",
               {a1, b1, c1, d1}, {na1, nb1, nc1, nd1}, busy1, done1, tbl1, cnt1, ff1, fv1, m1);
    end
    @(negedge clk); @(negedge clk);
    rst = 0;
  endtask

  task automatic test_golden();
    run_sweep(16'hF444, "golden");
  endtask

  task automatic test_mismatch();
    run_sweep(16'hF444 ^ 16'h0208, "mismatch");
  endtask

  task automatic test_abort();
    @(negedge clk);
    expected = 16'hF444;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    for (int cyc = 0; cyc < 21; cyc++) begin
      @(negedge clk);
      if (cyc == 15) start = 1;
      if (cyc == 16) start = 0;
      if (cyc == 17 || cyc == 20) begin
        checks++;
        if ({a1, b1, c1, d1} !== ((cyc == 17) ? 4'd5 : 4'd6) || busy1 !== 1'b1) begin
          errors++;
          $display("FAIL abort_ignore_start cyc %0d: vec=%0d busy=%b", cyc, {a1, b1, c1, d1}, busy1);
        end
      end
    end
    @(negedge clk);
    checks++;
    if ({a1, b1, c1, d1} !== 4'd7) begin
      errors++;
      $display("FAIL abort_pre_reset: vec=%0d want 7", {a1, b1, c1, d1});
    end
    #2 rst = 1;
    #1;
    checks++;
    if (busy1 !== 0 || done1 !== 0 || tbl1 !== 16'h0 || cnt1 !== 5'd0 ||
        {a1, b1, c1, d1} !== 4'd0 || {na1, nb1, nc1, nd1} !== 4'hF) begin
      errors++;
      $display("FAIL abort_reset: busy=%b done=%b tbl=%h cnt=%0d vec=%b not=%b",
               busy1, done1, tbl1, cnt1, {a1, b1, c1, d1}, {na1, nb1, nc1, nd1});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done1 !== 0 || busy1 !== 0) begin
        errors++;
        $display("FAIL abort_no_done: done=%b busy=%b", done1, busy1);
      end
    end
    rst = 0;
    run_sweep(16'hF444, "restart");
  endtask

  task automatic test_saturation();
    res_t r;
    r.tbl = 16'hFFFF; r.cnt = 5'd16; r.ff = 4'd0; r.fv = 1'b1; r.m = 1'b0;
    rq.push_back(r);
    @(negedge clk);
    expected2 = 16'h0000;
    start2 = 1;
    @(posedge clk);
    #1 start2 = 0;
    for (int cyc = 0; cyc < 32; cyc++) begin
      @(negedge clk);
      checks++;
      if (done2 !== 1'b0 || busy2 !== 1'b1) begin
        errors++;
        $display("FAIL sat busy/done cyc %0d: busy=%b done=%b", cyc, busy2, done2);
      end
    end
    @(negedge clk);
    checks++;
    if (done2 !== 1'b1) begin
      errors++;
      $display("FAIL sat done_timing: done=%b want 1", done2);
    end
    @(negedge clk);
    checks++;
    if (done2 !== 1'b0) begin
      errors++;
      $display("FAIL sat done_pulse: done=%b want 0", done2);
    end
    check_results("saturation", tbl2, cnt2, ff2, fv2, m2);
  endtask

  initial begin
    test_reset();
    test_golden();
    test_mismatch();
    test_abort();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
